// File: rtl/des_sched_if.sv
// Job-control and engine-array signals shared by the key-search scheduler,
// its host and its engines.
interface des_sched_if #(parameter int NCORE = 4);
  logic                go;
  logic                abort;
  logic [55:0]         key_first;
  logic [55:0]         key_last;
  logic                busy;
  logic                found;
  logic [55:0]         found_key;
  logic [31:0]         chunks_done;
  logic [NCORE-1:0]    core_run;
  logic [55:0]         core_base;
  logic                core_abort;
  logic [NCORE-1:0]    core_idle;
  logic [NCORE-1:0]    core_done;
  logic [NCORE-1:0]    core_hit;
  logic [56*NCORE-1:0] core_key;

  modport slave (
    input  go, abort, key_first, key_last, core_idle, core_done, core_hit, core_key,
    output busy, found, found_key, chunks_done, core_run, core_base, core_abort
  );

  modport master (
    output go, abort, key_first, key_last, core_idle, core_done, core_hit, core_key,
    input  busy, found, found_key, chunks_done, core_run, core_base, core_abort
  );
endinterface

// File: rtl/des_sched.sv
// Splits a key range into 2^CHUNK_LOG2-key chunks and hands them to idle search engines.
// IDLE: wait for go | DISPATCH: hand out chunks | DRAIN: wait for outstanding | FLUSH: wait all idle
module des_sched #(
  parameter int NCORE      = 4,
  parameter int CHUNK_LOG2 = 24
) (
  input  logic        clk,
  input  logic        rstn,
  des_sched_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, DISPATCH, DRAIN, FLUSH} state_t;

  localparam logic [55:0] LOW_MASK = (56'd1 << CHUNK_LOG2) - 56'd1;
  localparam logic [56:0] STEP     = 57'd1 << CHUNK_LOG2;

  state_t           state_q, state_d;
  logic [55:0]      next_q, next_d, last_q, last_d;
  logic             busy_q, busy_d, found_q, found_d, core_abort_q, core_abort_d;
  logic [55:0]      found_key_q, found_key_d, core_base_q, core_base_d;
  logic [31:0]      chunks_done_q, chunks_done_d;
  logic [NCORE-1:0] core_run_q, core_run_d, outst_q, outst_d;

  logic [NCORE-1:0] done_v, hit_v, elig, run_sel;
  logic [31:0]      done_cnt;
  logic [55:0]      hit_key;
  logic [56:0]      next_inc;

  // Only engines we actually dispatched to count as done or hit.
  always_comb begin
    done_v   = bus.core_done & outst_q;
    hit_v    = done_v & bus.core_hit;
    elig     = bus.core_idle & ~outst_q;
    done_cnt = '0;
    hit_key  = '0;
    run_sel  = '0;
    for (int i = NCORE - 1; i >= 0; i--) begin
      if (done_v[i]) done_cnt = done_cnt + 32'd1;
      if (hit_v[i]) hit_key = bus.core_key[56*i +: 56];
      if (elig[i]) begin
        run_sel    = '0;
        run_sel[i] = 1'b1;
      end
    end
    next_inc = {1'b0, next_q} + STEP;
  end

  always_comb begin
    state_d       = state_q;
    next_d        = next_q;
    last_d        = last_q;
    busy_d        = busy_q;
    found_d       = found_q;
    found_key_d   = found_key_q;
    chunks_done_d = chunks_done_q;
    core_run_d    = '0;
    core_base_d   = core_base_q;
    core_abort_d  = 1'b0;
    outst_d       = outst_q;
    case (state_q)
      IDLE: begin
        if (bus.go && !bus.abort) begin
          next_d        = bus.key_first & ~LOW_MASK;
          last_d        = bus.key_last & ~LOW_MASK;
          found_d       = 1'b0;
          found_key_d   = '0;
          chunks_done_d = '0;
          busy_d        = 1'b1;
          state_d       = DISPATCH;
        end
      end
      DISPATCH, DRAIN: begin
        chunks_done_d = chunks_done_q + done_cnt;
        outst_d       = outst_q & ~done_v;
        if (hit_v != '0 && !found_q) begin
          found_d      = 1'b1;
          found_key_d  = hit_key;
          core_abort_d = 1'b1;
          outst_d      = '0;
          state_d      = FLUSH;
        end else if (bus.abort) begin
          core_abort_d = 1'b1;
          outst_d      = '0;
          state_d      = FLUSH;
        end else if (state_q == DISPATCH) begin
          if (elig != '0) begin
            core_run_d  = run_sel;
            core_base_d = next_q;
            outst_d     = outst_d | run_sel;
            next_d      = next_inc[55:0];
            // A carry out means the following base would wrap; never issue it.
            if (next_q == last_q || next_inc[56]) state_d = DRAIN;
          end
        end else if (outst_d == '0) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      FLUSH: begin
        if (&bus.core_idle) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q       <= IDLE;
      next_q        <= '0;
      last_q        <= '0;
      busy_q        <= 1'b0;
      found_q       <= 1'b0;
      found_key_q   <= '0;
      chunks_done_q <= '0;
      core_run_q    <= '0;
      core_base_q   <= '0;
      core_abort_q  <= 1'b0;
      outst_q       <= '0;
    end else begin
      state_q       <= state_d;
      next_q        <= next_d;
      last_q        <= last_d;
      busy_q        <= busy_d;
      found_q       <= found_d;
      found_key_q   <= found_key_d;
      chunks_done_q <= chunks_done_d;
      core_run_q    <= core_run_d;
      core_base_q   <= core_base_d;
      core_abort_q  <= core_abort_d;
      outst_q       <= outst_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.found       = found_q;
  assign bus.found_key   = found_key_q;
  assign bus.chunks_done = chunks_done_q;
  assign bus.core_run    = core_run_q;
  assign bus.core_base   = core_base_q;
  assign bus.core_abort  = core_abort_q;
endmodule

// File: doc/des_sched.md
DES_SCHED -- requirements
Module: des_sched

Interface
REQ-001 Parameter NCORE, default 4, SHALL set the number of managed key-search engines (1..16).
REQ-002 Parameter CHUNK_LOG2, default 24, SHALL set log2 of the keys searched per chunk (8..48).
REQ-003 clk  in  1  sole clock; all logic SHALL be rising-edge.
REQ-004 rstn  in  1  reset; synchronous and active-low.
REQ-005 go  in  1  single-cycle pulse; starts a search job.
REQ-006 abort  in  1  level; ends the current job.
REQ-007 key_first  in  56  first key of the job; low CHUNK_LOG2 bits are ignored (treated as 0).
REQ-008 key_last  in  56  last key of the job; low CHUNK_LOG2 bits are ignored; the chunk containing it is searched.
REQ-009 busy  out  1  high while a job is active.
REQ-010 found  out  1  sticky hit flag for the last job.
REQ-011 found_key  out  56  key reported by the first hit.
REQ-012 chunks_done  out  32  count of completed chunks in the current job.
REQ-013 core_run  out  NCORE  one-hot, single-cycle dispatch pulse.
REQ-014 core_base  out  56  chunk base key; valid in the core_run cycle.
REQ-015 core_abort  out  1  single-cycle pulse; all engines stop and return idle.
REQ-016 core_idle  in  NCORE  engine i is ready for a chunk.
REQ-017 core_done  in  NCORE  single-cycle pulse; engine i finished its chunk.
REQ-018 core_hit  in  NCORE  qualifies core_done[i]; engine i found a match.
REQ-019 core_key  in  56*NCORE  matching key of engine i, slice [56*i+55:56*i]; valid with core_done&core_hit.

Function
REQ-020 FSM states SHALL be IDLE, DISPATCH, DRAIN and FLUSH.
REQ-021 IDLE + go: the block SHALL latch next=key_first with low bits cleared and last=key_last with low bits cleared, clear found, found_key and chunks_done, set busy, and go to DISPATCH on the next cycle.
REQ-022 In IDLE, go SHALL be ignored when abort is high in the same cycle.
REQ-023 While busy, go SHALL be ignored.
REQ-024 DISPATCH: each cycle the block SHALL pulse core_run for at most one engine, choosing the lowest index i with core_idle[i]=1 and not dispatched-outstanding.
REQ-025 On each dispatch: core_base=next, then next += 2^CHUNK_LOG2.
REQ-026 An engine SHALL stay outstanding from its core_run pulse until its core_done pulse.
REQ-027 The block SHALL enter DRAIN after dispatching the chunk whose base equals last.
REQ-028 The block SHALL also enter DRAIN if next wraps past 2^56-1; no chunk SHALL be dispatched with a wrapped base.
REQ-029 Each core_done pulse SHALL add 1 to chunks_done; several simultaneous pulses SHALL add their popcount in that cycle.
REQ-030 On the first core_done&core_hit of a job: found SHALL be set and found_key SHALL take core_key of the lowest such index; later hits SHALL be ignored.
REQ-031 The first hit SHALL also pulse core_abort and move to FLUSH.
REQ-032 DRAIN: the block SHALL go to IDLE and clear busy once no engine is outstanding.
REQ-033 abort in DISPATCH or DRAIN SHALL pulse core_abort and go to FLUSH; found SHALL remain as is.
REQ-034 FLUSH: the block SHALL wait until core_idle is all-ones, then go to IDLE and clear busy.
REQ-035 In FLUSH the block SHALL issue no core_run and SHALL ignore core_done.
REQ-036 A core_done pulse with no engine outstanding SHALL be ignored.

Reset
REQ-037 When rstn=0 at a clock edge: state=IDLE, busy=0, found=0, found_key=0, chunks_done=0, core_run=0, core_base=0, core_abort=0.
REQ-038 A reset during a job SHALL drop it with no core_abort pulse; engines are reset by the same rstn.

Verification
REQ-039 NCORE=4, CHUNK_LOG2=8, key_first=0, key_last=0x3FF, all idle, no hits -> core_run 0001,0010,0100,1000 on consecutive cycles with bases 0,0x100,0x200,0x300; after 4 done pulses chunks_done=4, busy=0, found=0.
REQ-040 Range of 6 chunks, 4 cores -> chunks 5 and 6 go to the first cores to return done; chunks_done=6 at the end.
REQ-041 core_done on cores 2 and 1 in the same cycle, both hits, keys 0xAA and 0xBB -> found_key=0xBB, one core_abort pulse, FLUSH until all idle, then busy=0.
REQ-042 abort asserted in the 3rd DISPATCH cycle -> one core_abort pulse, no further core_run, busy falls when core_idle=all-ones, found=0.
REQ-043 key_first=key_last=0xFFFFFFFFFFFF00 with CHUNK_LOG2=8 -> exactly one dispatch, base 0xFFFFFFFFFFFF00, no wrapped base, busy clears after done.
REQ-044 rstn low mid-DISPATCH -> next cycle all outputs equal the REQ-037 reset values and go is accepted again.
